// File: rtl/bcd_scan_display.sv
// bcd_scan_display: multiplexed seven-segment driver for a BCD counter chain.
// A latch strobe snapshots the digits; a prescaler steps a digit index that
// drives one active-low digit enable at a time onto a shared segment bus.
module bcd_scan_display #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic              latch,
  input  logic              en,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              tick,
  output logic              invalid
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [4*NDIG-1:0] snap;
  logic [PW-1:0]     pre;
  logic [IW-1:0]     idx;
  logic              wrap;

  logic [3:0]        cur;
  logic              blank;
  logic              any_bad;
  logic              higher_nz;
  logic [6:0]        seg_d;
  logic [NDIG-1:0]   an_d;

  assign wrap = (pre == PW'(PRESCALE - 1));

  // Digit snapshot register, loaded on every edge that latch is high.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      snap <= '0;
    end else if (latch) begin
      snap <= bcd_in;
    end
  end

  // Prescaler and digit index; both freeze while the scan is disabled.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pre  <= '0;
      idx  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      tick <= wrap;
      if (wrap) begin
        pre <= '0;
        idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Select the current digit, decide leading-zero blanking and decode it.
  // higher_nz accumulates from the top digit down, so at digit k it tells
  // whether any of digits k..NDIG-1 is non-zero (invalid codes count too).
  always_comb begin
    cur       = '0;
    blank     = 1'b0;
    any_bad   = 1'b0;
    higher_nz = 1'b0;
    an_d      = '1;
    seg_d     = '0;
    for (int unsigned j = 0; j < NDIG; j++) begin
      int unsigned k;
      k = NDIG - 1 - j;
      if (snap[4*k +: 4] > 4'd9) begin
        any_bad = 1'b1;
      end
      if (snap[4*k +: 4] != 4'd0) begin
        higher_nz = 1'b1;
      end
      if (IW'(k) == idx) begin
        cur     = snap[4*k +: 4];
        an_d[k] = 1'b0;
        blank   = BLANK_LZ && (k != 0) && !higher_nz;
      end
    end
    case (cur)
      4'd0:    seg_d = 7'h3F;
      4'd1:    seg_d = 7'h06;
      4'd2:    seg_d = 7'h5B;
      4'd3:    seg_d = 7'h4F;
      4'd4:    seg_d = 7'h66;
      4'd5:    seg_d = 7'h6D;
      4'd6:    seg_d = 7'h7D;
      4'd7:    seg_d = 7'h07;
      4'd8:    seg_d = 7'h7F;
      4'd9:    seg_d = 7'h6F;
      default: seg_d = 7'h40;
    endcase
    if (blank) begin
      seg_d = '0;
    end
  end

  // Registered display outputs; disabling the scan blanks everything.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      seg     <= '0;
      an      <= '1;
      invalid <= 1'b0;
    end else begin
      invalid <= any_bad;
      if (en) begin
        seg <= seg_d;
        an  <= an_d;
      end else begin
        seg <= '0;
        an  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display (NDIG=4, PRESCALE=4, BLANK_LZ=1).
module tb_bcd_scan_display;

  logic        clk;
  logic        clr;
  logic [15:0] bcd_in;
  logic        latch;
  logic        en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        tick;
  logic        invalid;

  int checks   = 0;
  int failures = 0;

  // Reference state: snapshot, prescaler, digit index.
  logic [15:0] m_snap;
  int          m_pre;
  int          m_idx;

  // Scoreboard entries: {an[3:0], seg[6:0], tick, invalid}.
  logic [12:0] sbq[$];

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  bcd_scan_display #(
    .NDIG(4),
    .PRESCALE(4),
    .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bcd_in(bcd_in),
    .latch(latch),
    .en(en),
    .seg(seg),
    .an(an),
    .tick(tick),
    .invalid(invalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] seg_of(input logic [15:0] s, input int k);
    logic [15:0] above;
    logic [3:0]  d;
    above = s >> (4 * k);
    d     = s[4*k +: 4];
    if (k > 0 && above == 16'h0) return 7'h00;
    return lut[d];
  endfunction

  function automatic logic inv_of(input logic [15:0] s);
    for (int k = 0; k < 4; k++) begin
      if (s[4*k +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: push the expected registered outputs, take the edge,
  // advance the reference state, then settle 1 time unit past the edge.
  task automatic cycle();
    logic [12:0] e;
    if (!clr) begin
      e = {4'b1111, 7'h00, 1'b0, 1'b0};
    end else begin
      e[12:9] = en ? ~(4'b0001 << m_idx) : 4'b1111;
      e[8:2]  = en ? seg_of(m_snap, m_idx) : 7'h00;
      e[1]    = en && (m_pre == 3);
      e[0]    = inv_of(m_snap);
    end
    sbq.push_back(e);
    @(posedge clk);
    if (!clr) begin
      m_snap = '0;
      m_pre  = 0;
      m_idx  = 0;
    end else begin
      if (latch) m_snap = bcd_in;
      if (en) begin
        if (m_pre == 3) begin
          m_pre = 0;
          m_idx = (m_idx + 1) % 4;
        end else begin
          m_pre++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    clr = 1'b0; en = 1'b1; latch = 1'b0; bcd_in = 16'h0;
    m_snap = '0; m_pre = 0; m_idx = 0;
    for (int c = 0; c < 2; c++) begin
      cycle(); e = sbq.pop_front(); checks++;
      if ({an, seg, tick, invalid} !== e) begin
        failures++;
        $display("FAIL reset_hold got=%h want=%h", {an, seg, tick, invalid}, e);
      end
    end
    clr = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cycle(); e = sbq.pop_front(); checks++;
      if ({an, seg, tick, invalid} !== e) begin
        failures++;
        $display("FAIL reset_release c=%0d got=%h want=%h", c, {an, seg, tick, invalid}, e);
      end
      if (c == 1) begin
        checks++;
        if (an !== 4'b1110) begin failures++; $display("FAIL first_an got=%b want=1110", an); end
      end
      if (c == 4) begin
        checks++;
        if (tick !== 1'b1) begin failures++; $display("FAIL first_tick got=%b want=1", tick); end
      end
      if (c == 5) begin
        checks++;
        if (an !== 4'b1101) begin failures++; $display("FAIL second_an got=%b want=1101", an); end
      end
    end
  endtask

  task automatic test_decode();
    logic [12:0] e;
    logic [6:0]  got [4];
    logic [6:0]  want [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    int          ticks;
    for (int k = 0; k < 4; k++) got[k] = 7'h55;
    bcd_in = 16'h1234; latch = 1'b1;
    cycle(); e = sbq.pop_front(); checks++;
    if ({an, seg, tick, invalid} !== e) begin
      failures++;
      $display("FAIL decode_latch got=%h want=%h", {an, seg, tick, invalid}, e);
    end
    latch = 1'b0; bcd_in = 16'h9999;
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(); e = sbq.pop_front(); checks++;
      if ({an, seg, tick, invalid} !== e) begin
        failures++;
        $display("FAIL decode_scan c=%0d got=%h want=%h", c, {an, seg, tick, invalid}, e);
      end
      if (c < 16 && tick === 1'b1) ticks++;
      for (int k = 0; k < 4; k++) if (an === ~(4'b0001 << k)) got[k] = seg;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== want[k]) begin
        failures++;
        $display("FAIL decode_digit%0d got=%h want=%h", k, got[k], want[k]);
      end
    end
    checks++;
    if (ticks != 4) begin failures++; $display("FAIL tick_rate got=%0d want=4", ticks); end
  endtask

  task automatic test_blank();
    logic [12:0] e;
    logic [6:0]  got [4];
    logic [15:0] pat [2]  = '{16'h0070, 16'h0000};
    logic [6:0]  want [8] = '{7'h3F, 7'h07, 7'h00, 7'h00, 7'h3F, 7'h00, 7'h00, 7'h00};
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) got[k] = 7'h55;
      bcd_in = pat[p]; latch = 1'b1;
      cycle(); e = sbq.pop_front(); checks++;
      if ({an, seg, tick, invalid} !== e) begin
        failures++;
        $display("FAIL blank_latch p=%0d got=%h want=%h", p, {an, seg, tick, invalid}, e);
      end
      latch = 1'b0;
      for (int c = 0; c < 17; c++) begin
        cycle(); e = sbq.pop_front(); checks++;
        if ({an, seg, tick, invalid} !== e) begin
          failures++;
          $display("FAIL blank_scan p=%0d c=%0d got=%h want=%h", p, c, {an, seg, tick, invalid}, e);
        end
        for (int k = 0; k < 4; k++) if (an === ~(4'b0001 << k)) got[k] = seg;
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== want[4*p + k]) begin
          failures++;
          $display("FAIL blank_digit p=%0d k=%0d got=%h want=%h", p, k, got[k], want[4*p + k]);
        end
      end
    end
  endtask

  task automatic test_invalid();
    logic [12:0] e;
    logic [6:0]  got [4];
    logic [6:0]  want [4] = '{7'h6D, 7'h40, 7'h00, 7'h00};
    for (int k = 0; k < 4; k++) got[k] = 7'h55;
    bcd_in = 16'h00A5; latch = 1'b1;
    cycle(); e = sbq.pop_front(); checks++;
    if ({an, seg, tick, invalid} !== e) begin
      failures++;
      $display("FAIL inv_latch got=%h want=%h", {an, seg, tick, invalid}, e);
    end
    latch = 1'b0;
    for (int c = 0; c < 17; c++) begin
      cycle(); e = sbq.pop_front(); checks++;
      if ({an, seg, tick, invalid} !== e) begin
        failures++;
        $display("FAIL inv_scan c=%0d got=%h want=%h", c, {an, seg, tick, invalid}, e);
      end
      if (c == 0) begin
        checks++;
        if (invalid !== 1'b1) begin failures++; $display("FAIL inv_set got=%b want=1", invalid); end
      end
      for (int k = 0; k < 4; k++) if (an === ~(4'b0001 << k)) got[k] = seg;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== want[k]) begin
        failures++;
        $display("FAIL inv_digit%0d got=%h want=%h", k, got[k], want[k]);
      end
    end
    bcd_in = 16'h0005; latch = 1'b1;
    cycle(); e = sbq.pop_front(); checks++;
    if ({an, seg, tick, invalid} !== e) begin
      failures++;
      $display("FAIL inv_relatch got=%h want=%h", {an, seg, tick, invalid}, e);
    end
    latch = 1'b0;
    cycle(); e = sbq.pop_front(); checks++;
    if (invalid !== 1'b0 || {an, seg, tick, invalid} !== e) begin
      failures++;
      $display("FAIL inv_clear got=%h want=%h", {an, seg, tick, invalid}, e);
    end
  endtask

  task automatic test_enable();
    logic [12:0] e;
    int          n;
    bcd_in = 16'h1234; latch = 1'b1;
    cycle(); e = sbq.pop_front(); checks++;
    if ({an, seg, tick, invalid} !== e) begin
      failures++;
      $display("FAIL en_latch got=%h want=%h", {an, seg, tick, invalid}, e);
    end
    latch = 1'b0;
    n = 0;
    while (!(m_pre == 2 && m_idx == 2) && n < 40) begin
      cycle(); e = sbq.pop_front(); checks++; n++;
      if ({an, seg, tick, invalid} !== e) begin
        failures++;
        $display("FAIL en_seek got=%h want=%h", {an, seg, tick, invalid}, e);
      end
    end
    checks++;
    if (!(m_pre == 2 && m_idx == 2)) begin
      failures++;
      $display("FAIL en_seek_timeout got=pre%0d/idx%0d want=pre2/idx2", m_pre, m_idx);
    end
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle(); e = sbq.pop_front(); checks++;
      if ({an, seg, tick, invalid} !== e || an !== 4'b1111 || seg !== 7'h00 || tick !== 1'b0) begin
        failures++;
        $display("FAIL en_off c=%0d got=%h want=%h", c, {an, seg, tick, invalid}, e);
      end
    end
    en = 1'b1;
    cycle(); e = sbq.pop_front(); checks++;
    if ({an, seg, tick, invalid} !== e || an !== 4'b1011 || seg !== 7'h5B || tick !== 1'b0) begin
      failures++;
      $display("FAIL en_resume got=%h want=%h", {an, seg, tick, invalid}, e);
    end
    cycle(); e = sbq.pop_front(); checks++;
    if ({an, seg, tick, invalid} !== e || tick !== 1'b1) begin
      failures++;
      $display("FAIL en_resume_tick got=%h want=%h", {an, seg, tick, invalid}, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    logic [6:0]  tab [4] = '{7'h7D, 7'h07, 7'h7F, 7'h6F};
    int          n;
    n = 0;
    while (m_pre != 3 && n < 10) begin
      cycle(); e = sbq.pop_front(); checks++; n++;
      if ({an, seg, tick, invalid} !== e) begin
        failures++;
        $display("FAIL b2b_seek got=%h want=%h", {an, seg, tick, invalid}, e);
      end
    end
    bcd_in = 16'h9876; latch = 1'b1;
    cycle(); e = sbq.pop_front(); checks++;
    if ({an, seg, tick, invalid} !== e || tick !== 1'b1) begin
      failures++;
      $display("FAIL b2b_wrap got=%h want=%h", {an, seg, tick, invalid}, e);
    end
    latch = 1'b0;
    cycle(); e = sbq.pop_front(); checks++;
    if ({an, seg, tick, invalid} !== e || seg !== tab[m_idx] || an !== ~(4'b0001 << m_idx)) begin
      failures++;
      $display("FAIL b2b_newdigit got=%h want=%h", {an, seg, tick, invalid}, e);
    end
    latch = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      cycle(); e = sbq.pop_front(); checks++;
      if ({an, seg, tick, invalid} !== e) begin
        failures++;
        $display("FAIL b2b_track c=%0d got=%h want=%h", c, {an, seg, tick, invalid}, e);
      end
    end
    latch = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [12:0] e;
    int          n;
    bcd_in = 16'h0B00; latch = 1'b1;
    cycle(); e = sbq.pop_front(); checks++;
    if ({an, seg, tick, invalid} !== e) begin
      failures++;
      $display("FAIL ar_latch got=%h want=%h", {an, seg, tick, invalid}, e);
    end
    latch = 1'b0;
    n = 0;
    do begin
      cycle(); e = sbq.pop_front(); checks++; n++;
      if ({an, seg, tick, invalid} !== e) begin
        failures++;
        $display("FAIL ar_seek got=%h want=%h", {an, seg, tick, invalid}, e);
      end
    end while (tick !== 1'b1 && n < 10);
    clr = 1'b0;
    #2;
    m_snap = '0; m_pre = 0; m_idx = 0;
    checks++;
    if ({an, seg, tick, invalid} !== {4'b1111, 7'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL ar_immediate got=%h want=%h", {an, seg, tick, invalid}, {4'b1111, 7'h00, 1'b0, 1'b0});
    end
    cycle(); e = sbq.pop_front(); checks++;
    if ({an, seg, tick, invalid} !== e) begin
      failures++;
      $display("FAIL ar_hold got=%h want=%h", {an, seg, tick, invalid}, e);
    end
    clr = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cycle(); e = sbq.pop_front(); checks++;
      if ({an, seg, tick, invalid} !== e) begin
        failures++;
        $display("FAIL ar_restart c=%0d got=%h want=%h", c, {an, seg, tick, invalid}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_blank();
    test_invalid();
    test_enable();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Multiplexed seven-segment display driver that consumes the BCD digit outputs of the decade counter chain. A latch strobe snapshots the digits. The block time-multiplexes them onto one shared segment bus with active-low digit enables. It sits directly downstream of the mod-10 counter stages and is the last stage before the board display pins.

Parameters:
NDIG, 4, number of BCD digits scanned (2..8)
PRESCALE, 1000, clk cycles each digit stays lit (>=2)
BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset, all state cleared while low
bcd_in  input  4*NDIG  BCD digits; digit k at [4k+3:4k], digit 0 least significant
latch  input  1  snapshot bcd_in into the internal digit register on this edge
en  input  1  scan enable; 0 blanks the display and freezes the scan
seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
an  output  NDIG  digit enables, active-low one-hot, registered
tick  output  1  one-cycle pulse on each digit advance, registered
invalid  output  1  1 while any snapshot digit > 9, registered

Behaviour:
- Reset (clr=0, async):
  - snapshot = 0, prescaler = 0, idx = 0.
  - seg = 7'h00, an = all ones, tick = 0, invalid = 0.
- Snapshot:
  - On each rising edge with latch=1, snapshot <= bcd_in.
  - With latch held high, the snapshot tracks bcd_in every cycle.
- Prescaler, while en=1:
  - Counts 0..PRESCALE-1.
  - On the edge where it equals PRESCALE-1, it wraps to 0, idx <= (idx+1) mod NDIG, and tick <= 1 for exactly one cycle.
- en=0:
  - prescaler and idx hold their values; tick = 0.
  - From the next edge, an = all ones and seg = 0.
  - When en returns to 1, the scan resumes from the held idx and prescaler values.
- Output pipeline:
  - seg, an and invalid register the combinational decode of the current snapshot and idx.
  - The display therefore reflects a latch sampled at edge t from edge t+1 onward, i.e. visible in the cycle after t+1.
  - An idx change at edge t appears on an/seg at edge t+1.
- an: bit idx low, all other bits high.
- Segment decode (hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 display a dash = 40.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k (k>=1) is blanked (seg=00, an bit still driven low) when digit k and every higher digit equal 0.
  - Digit 0 is never blanked, so 0000 shows "0".
  - Invalid codes count as non-zero.
- invalid: 1 when any snapshot digit is in 10..15; updates one edge after the snapshot changes. It is not sticky.
- Simultaneous latch and tick on the same edge: both take effect. The next displayed digit uses the new snapshot, following the pipeline rule above.
- Reset mid-scan: immediate blank output. After clr releases, scanning restarts at digit 0 with a full PRESCALE period.
- bcd_in is synchronous to clk. Upstream ripple outputs are sampled only via latch.

Test Plan:
- Reset: PRESCALE=4, clr=0 with en=1 -> an=1111, seg=00, tick=0. Release clr -> first tick on the 4th edge; an=1110 one edge after release, then 1101 one edge after the first tick.
- Decode: latch bcd_in=16'h1234, en=1 -> across the scan, digit 0 shows seg=66 (an=1110), digit 1 shows 4F, digit 2 shows 5B, digit 3 shows 06. tick pulses every 4 cycles; idx wraps 3->0.
- Blanking: latch 16'h0070 with BLANK_LZ=1 -> digit 3 seg=00, digit 2 seg=00, digit 1 seg=07, digit 0 seg=3F. Latch 16'h0000 -> only digit 0 lit, seg=3F.
- Invalid: latch 16'h00A5 -> invalid=1, digit 1 seg=40, digit 2 seg=00 (blanked). Latch 16'h0005 -> invalid=0 one edge after the snapshot changes.
- Enable: drop en mid-slot at prescaler=2, idx=2 -> next edge an=1111, seg=00, no tick. Restore en -> an=1011 resumes, tick after 2 more cycles.
- Latch/tick collision: assert latch on the wrap edge with a new value -> the new digit appears without glitching and matches the documented pipeline timing. Asserting clr mid-slot blanks outputs asynchronously.
